// File: rtl/rdr_fifo_if.sv
// Receiver-side capture handshake and host-side drain port of the receive buffer.
// The slave modport is the buffer; the master modport is whoever drives it.
interface rdr_fifo_if #(
  parameter int DATA_SIZE = 8,
  parameter int DEPTH     = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [DATA_SIZE-1:0] d_i;
  logic                 data_ready;
  logic                 frame_error;
  logic                 data_read_ack;
  logic                 rd_en;
  logic [DATA_SIZE-1:0] d_o;
  logic                 fe_o;
  logic                 empty;
  logic                 full;
  logic [CNT_W-1:0]     count;
  logic                 overrun;
  logic                 ovr_clr;
  logic [7:0]           fe_cnt;

  modport master (
    output d_i, data_ready, frame_error, rd_en, ovr_clr,
    input  data_read_ack, d_o, fe_o, empty, full, count, overrun, fe_cnt
  );

  modport slave (
    input  d_i, data_ready, frame_error, rd_en, ovr_clr,
    output data_read_ack, d_o, fe_o, empty, full, count, overrun, fe_cnt
  );
endinterface

// File: rtl/rdr_fifo.sv
// UART receive buffer: edge-detected capture of receiver words into a
// first-word-fall-through FIFO, with sticky overrun and frame-error counting.
module rdr_fifo #(
  parameter int DATA_SIZE = 8,
  parameter int DEPTH     = 4,
  parameter int DROP_FE   = 0
) (
  input logic       clk,
  input logic       res,
  rdr_fifo_if.slave bus
);
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = DATA_SIZE + 1;

  logic [ENTRY_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic               r_dr_q;
  logic               r_ack;
  logic               r_ovr;
  logic [7:0]         r_fe_cnt;

  logic               w_empty;
  logic               w_full;
  logic               w_accept;
  logic               w_pop;
  logic               w_discard;
  logic               w_store;
  logic               w_ovr_set;
  logic [ENTRY_W-1:0] w_head;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CNT_W'(DEPTH));

  // A data_ready level counts once; it must drop for a cycle before the next word.
  assign w_accept  = bus.data_ready & ~r_dr_q;
  assign w_pop     = bus.rd_en & ~w_empty;
  assign w_discard = w_accept & bus.frame_error & (DROP_FE != 0);
  assign w_store   = w_accept & ~w_discard & (~w_full | w_pop);
  assign w_ovr_set = w_accept & ~w_discard & w_full & ~w_pop;

  // NOTE: storage has no reset; validity comes solely from r_count, which keeps
  // the array free of reset fan-out and mappable onto plain RAM.
  always_ff @(posedge clk) begin
    if (w_store) r_mem[r_wr_ptr] <= {bus.frame_error, bus.d_i};
  end

  // NOTE: every sequential assignment is non-blocking so all registers update
  // from the same pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_dr_q   <= 1'b0;
      r_ack    <= 1'b0;
      r_ovr    <= 1'b0;
      r_fe_cnt <= '0;
    end else begin
      r_dr_q <= bus.data_ready;
      r_ack  <= w_accept;

      if (w_store) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)   r_rd_ptr <= r_rd_ptr + PTR_W'(1);

      case ({w_store, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase

      // A new overrun in the same cycle as a clear must survive.
      if (w_ovr_set)        r_ovr <= 1'b1;
      else if (bus.ovr_clr) r_ovr <= 1'b0;

      if (w_accept && bus.frame_error && (r_fe_cnt != 8'hFF))
        r_fe_cnt <= r_fe_cnt + 8'd1;
    end
  end

  assign w_head            = r_mem[r_rd_ptr];
  assign bus.d_o           = w_empty ? '0 : w_head[DATA_SIZE-1:0];
  assign bus.fe_o          = w_empty ? 1'b0 : w_head[DATA_SIZE];
  assign bus.empty         = w_empty;
  assign bus.full          = w_full;
  assign bus.count         = r_count;
  assign bus.overrun       = r_ovr;
  assign bus.data_read_ack = r_ack;
  assign bus.fe_cnt        = r_fe_cnt;
endmodule

// File: doc/rdr_fifo.md
# rdr_fifo

Parametrised receive data buffer for the UART receive path, successor to the single-word `rdr` register. Captures each word from the receiver shift stage together with its frame-error flag, acknowledges it, and queues it in a DEPTH-entry first-word-fall-through FIFO. The host side drains the FIFO at its own pace. Overruns are flagged sticky, and an optional mode discards framing-error words instead of storing them.

## Interface
- DATA_SIZE, 8: word width in bits, from 5 to 9.
- DEPTH, 4: FIFO entries; power of two, at least 2.
- DROP_FE, 0: 0 stores frame-error words with their flag; 1 discards them.

- clk  in  1  rising-edge clock; the only clock.
- res  in  1  asynchronous, active-low reset.
- d_i  in  DATA_SIZE  received word from the receiver; valid while data_ready=1.
- data_ready  in  1  receiver has a word, level signal.
- frame_error  in  1  stop-bit error for d_i; sampled with d_i.
- data_read_ack  out  1  one-cycle pulse: word taken (stored, dropped or discarded).
- rd_en  in  1  host pop request.
- d_o  out  DATA_SIZE  head entry data; 0 when empty.
- fe_o  out  1  head entry frame-error flag; 0 when empty.
- empty  out  1  FIFO holds no entries.
- full  out  1  count == DEPTH.
- count  out  $clog2(DEPTH)+1  number of stored entries.
- overrun  out  1  sticky: a word arrived while full.
- ovr_clr  in  1  clears overrun synchronously.
- fe_cnt  out  8  saturating count of frame-error words received (stored or discarded).

## Operation
- Reset (res=0, asynchronous) forces the following:
  - write pointer, read pointer and count are set to 0;
  - empty=1, full=0, overrun=0, data_read_ack=0, fe_cnt=0;
  - d_o=0 and fe_o=0;
  - dr_q, the registered data_ready, is set to 0;
  - memory contents are don't-care.
- Accept event: data_ready=1 and dr_q=0 at a rising edge. dr_q tracks data_ready every cycle.
  - A level held high is accepted once.
  - A new accept requires data_ready to go low for at least one cycle.
  - If data_ready is high at reset release, it is accepted on the first edge.
- On an accept, the block takes one of these actions:
  - frame_error=1 and DROP_FE=1: word discarded; fe_cnt increments.
  - Otherwise, when not full, or when full with a simultaneous valid pop: {frame_error, d_i} is written at the write pointer and the write pointer increments mod DEPTH. If frame_error=1, fe_cnt also increments.
  - Otherwise, when full with no pop: word dropped and overrun set to 1. fe_cnt still counts the error if frame_error=1.
  - In every case, data_read_ack=1 in the following cycle only.
- Pop: rd_en=1 and empty=0 increments the read pointer mod DEPTH. rd_en while empty is ignored, with no underflow.
- Count update:
  - +1 for a store;
  - -1 for a pop;
  - unchanged for a simultaneous store and pop, or for neither.
- empty, full and fe_o/d_o are derived from count and the read pointer (first-word-fall-through from the registered memory).
- overrun:
  - ovr_clr=1 clears it.
  - If set and clear happen in the same cycle, set wins.
- fe_cnt saturates at 255; it is cleared only by reset.

## Timing
- Accept at edge N:
  - the entry is visible on d_o/fe_o, with empty=0 and count updated, from edge N (during cycle N+1);
  - data_read_ack is high for cycle N+1 only.
- Pop at edge N: the next entry, or 0 if the FIFO is now empty, appears from edge N.
- Write-to-read latency is 1 cycle.
- Throughput:
  - write side: one word per 2 cycles at most, because of the data_ready low gap;
  - read side: one word per cycle.
- Pointer wrap: after DEPTH stores and DEPTH pops, both pointers return to 0 with no state disturbance.
- Reset mid-operation: all queued words are lost, and any ack pulse in flight is cancelled at once.

## Test plan
- Reset, then DATA_SIZE=7: present d_i=7'b1010111 with data_ready high for 3 cycles, frame_error=0. Required: one ack pulse; count=1; d_o=7'b1010111; fe_o=0; empty=0.
- DEPTH=4: write 0x11, 0x22, 0x33, 0x44, then a fifth word 0x55 with no pop. Required: full=1, count=4, overrun=1, ack still pulsed for 0x55. Popping 4 times yields 0x11, 0x22, 0x33, 0x44 in order, then empty=1 and d_o=0.
- Full FIFO: apply an accept of 0x66 and rd_en in the same cycle. Required: count stays 4, overrun stays 0, and the last pop returns 0x66.
- DROP_FE=0: word 0x3C with frame_error=1. Required: stored, fe_o=1 at head, fe_cnt=1. With DROP_FE=1 the same stimulus gives count=0, fe_cnt=1 and an ack pulse.
- Assert res low while 3 words are queued and data_ready is high. Required: immediately count=0, empty=1, overrun=0, ack=0. After release with data_ready still high, one word is captured.
- ovr_clr and a new overrun in the same cycle: overrun remains 1. Then 6 store/pop pairs wrap the pointers and data order is preserved.
